pattern_loader: RTL and testbench

PATTERN_LOADER -- requirements
Module: pattern_loader

---
 rtl/pattern_loader.sv | 141 ++++++++++++++
 tb/tb_pattern_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_loader.sv
// Streams pattern words from a FIFO into the imager mask shift chain, MSB first,
// pulsing Row_load after each row and Subc_done after the last row of a subscene.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_idle    | waiting for Sub_start
// S_fetch   | request next word from the FIFO (holds while FIFO empty)
// S_latch   | capture FIFO_dout into the shift register
// S_shift   | C_PAT_W serial cycles, MSB first
// S_rowload | one-cycle row latch pulse to the imager
// S_done    | one-cycle completion pulse, bump CntSubc
module pattern_loader #(
  parameter int C_NUM_ROWS      = 160,
  parameter int C_WORDS_PER_ROW = 18,
  parameter int C_PAT_W         = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Sub_start,
  input  logic               FIFO_empty,
  input  logic [C_PAT_W-1:0] FIFO_dout,
  input  logic               Cnt_clr,
  output logic               FIFO_rd,
  output logic               Mask_data,
  output logic               Mask_sclk_en,
  output logic               Row_load,
  output logic               Subc_done,
  output logic [31:0]        CntSubc,
  output logic               Busy,
  output logic               Stall
);

  localparam int RW = $clog2(C_NUM_ROWS + 1);
  localparam int WW = $clog2(C_WORDS_PER_ROW + 1);
  localparam int BW = $clog2(C_PAT_W + 1);

  localparam logic [RW-1:0] ROW_LAST  = RW'(C_NUM_ROWS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(C_WORDS_PER_ROW - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(C_PAT_W - 1);

  typedef enum logic [2:0] {
    S_idle    = 3'd0,
    S_fetch   = 3'd1,
    S_latch   = 3'd2,
    S_shift   = 3'd3,
    S_rowload = 3'd4,
    S_done    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_cnt_q, row_cnt_d;
  logic [WW-1:0]        word_cnt_q, word_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [C_PAT_W-1:0]   shreg_q, shreg_d;
  logic [31:0]          cnt_subc_q, cnt_subc_d;

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    cnt_subc_d = cnt_subc_q;

    case (state_q)
      S_idle: begin
        if (Sub_start) begin
          row_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = S_fetch;
        end
      end
      S_fetch: begin
        if (!FIFO_empty) state_d = S_latch;
      end
      S_latch: begin
        shreg_d   = FIFO_dout;
        bit_cnt_d = '0;
        state_d   = S_shift;
      end
      S_shift: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BIT_LAST) begin
          if (word_cnt_q == WORD_LAST) begin
            word_cnt_d = '0;
            state_d    = S_rowload;
          end else begin
            word_cnt_d = word_cnt_q + WW'(1);
            state_d    = S_fetch;
          end
        end
      end
      S_rowload: begin
        if (row_cnt_q == ROW_LAST) begin
          state_d = S_done;
        end else begin
          row_cnt_d = row_cnt_q + RW'(1);
          state_d   = S_fetch;
        end
      end
      S_done: begin
        cnt_subc_d = cnt_subc_q + 32'd1;
        state_d    = S_idle;
      end
      default: state_d = S_idle;
    endcase

    // A clear landing on the S_done cycle must beat the increment.
    if (Cnt_clr) cnt_subc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_idle;
      row_cnt_q  <= '0;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      cnt_subc_q <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      cnt_subc_q <= cnt_subc_d;
    end
  end

  // Outputs are state decodes, gated by rst so an abort drops them in the same cycle.
  assign FIFO_rd      = !rst && (state_q == S_fetch) && !FIFO_empty;
  assign Stall        = !rst && (state_q == S_fetch) && FIFO_empty;
  assign Mask_sclk_en = !rst && (state_q == S_shift);
  assign Mask_data    = Mask_sclk_en && shreg_q[C_PAT_W-1];
  assign Row_load     = !rst && (state_q == S_rowload);
  assign Subc_done    = !rst && (state_q == S_done);
  assign Busy         = !rst && (state_q != S_idle);
  assign CntSubc      = rst ? 32'd0 : cnt_subc_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Randomized bench for pattern_loader: reference model predicts the bit stream,
// row/read counts, completion time and CntSubc; a negedge monitor compares.
module tb_pattern_loader;

  localparam int ROWS   = 5;
  localparam int WPR    = 6;
  localparam int PW     = 10;
  localparam int NWORDS = ROWS * WPR;
  localparam int WT     = PW + 2;
  localparam int ROW_T  = WPR * WT + 1;
  localparam int DUR    = ROWS * ROW_T + 1;

  logic          clk = 1'b0;
  logic          rst, sub_start, cnt_clr, force_empty;
  logic          fifo_empty;
  logic [PW-1:0] fifo_dout = '0;
  logic          fifo_rd, mask_data, mask_sclk_en, row_load, subc_done, busy, stall;
  logic [31:0]   cnt_subc;

  pattern_loader #(
    .C_NUM_ROWS(ROWS), .C_WORDS_PER_ROW(WPR), .C_PAT_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .Sub_start(sub_start), .FIFO_empty(fifo_empty),
    .FIFO_dout(fifo_dout), .Cnt_clr(cnt_clr), .FIFO_rd(fifo_rd),
    .Mask_data(mask_data), .Mask_sclk_en(mask_sclk_en), .Row_load(row_load),
    .Subc_done(subc_done), .CntSubc(cnt_subc), .Busy(busy), .Stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears the cycle after the read strobe
  logic [PW-1:0] mem [0:1023];
  int pushed = 0;
  int popped = 0;
  assign fifo_empty = (pushed == popped) || force_empty;
  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) begin
      fifo_dout <= mem[popped % 1024];
      popped    <= popped + 1;
    end
  end

  // reference expectations written by stimulus
  bit ebits [0:4095];
  int ewr = 0;
  int run_ones = 0;
  int exp_stall = 0;

  // monitor state
  int checks = 0;
  int errors = 0;
  int erd = 0;
  bit in_run = 0;
  int start_cyc = 0;
  int exp_cnt = 0;
  int rows_seen, reads, ones_seen, stall_seen;
  int done_cnt = 0;

  task automatic chk_eq(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit was_run, done_exp;
    int act_sum;
    was_run = in_run;
    if (rst) begin
      chk_eq("rst_outputs", {fifo_rd, mask_data, mask_sclk_en, row_load, subc_done, busy, stall}, 0);
      chk_eq("rst_cntsubc", cnt_subc, 0);
      exp_cnt = 0;
      in_run  = 0;
    end else begin
      done_exp = was_run && ((cyc - start_cyc) == DUR + exp_stall);
      chk_eq("cntsubc", cnt_subc, exp_cnt);
      chk_eq("busy", busy, was_run);
      chk_eq("subc_done_time", subc_done, done_exp);
      act_sum = int'(fifo_rd) + int'(mask_sclk_en) + int'(row_load) + int'(subc_done);
      chk_eq("exclusive_strobes", act_sum <= 1, 1);
      if (!was_run) chk_eq("idle_quiet", {fifo_rd, mask_sclk_en, row_load, stall}, 0);
      if (stall) begin
        stall_seen++;
        chk_eq("stall_needs_empty", fifo_empty, 1);
      end
      if (fifo_rd) begin
        reads++;
        chk_eq("read_nonempty", fifo_empty, 0);
      end
      if (mask_sclk_en) begin
        chk_eq("bit_expected", erd < ewr, 1);
        if (erd < ewr) begin
          chk_eq("mask_bit", mask_data, ebits[erd % 4096]);
          erd++;
        end
        if (mask_data) ones_seen++;
      end
      if (row_load) rows_seen++;
      if (done_exp) begin
        chk_eq("row_loads", rows_seen, ROWS);
        chk_eq("fifo_reads", reads, NWORDS);
        chk_eq("bits_left", ewr - erd, 0);
        chk_eq("ones_count", ones_seen, run_ones);
        chk_eq("stall_cycles", stall_seen, exp_stall);
        in_run = 0;
        done_cnt++;
      end
      if (cnt_clr) exp_cnt = 0;
      else if (done_exp) exp_cnt++;
      if (sub_start && !was_run) begin
        in_run     = 1;
        start_cyc  = cyc;
        rows_seen  = 0;
        reads      = 0;
        ones_seen  = 0;
        stall_seen = 0;
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: all 2AA, mode 1: first 200 then zeros, mode 2: random
  task automatic load(input int mode);
    logic [PW-1:0] w;
    run_ones = 0;
    for (int i = 0; i < NWORDS; i++) begin
      case (mode)
        0:       w = 10'h2AA;
        1:       w = (i == 0) ? 10'h200 : 10'h000;
        default: w = PW'($urandom);
      endcase
      mem[pushed % 1024] = w;
      pushed++;
      for (int b = PW - 1; b >= 0; b--) begin
        ebits[ewr % 4096] = w[b];
        ewr++;
        if (w[b]) run_ones++;
      end
    end
  endtask

  task automatic run_sub(input int stall_off, input int stall_len, input int restart_at,
                         input bit clr_at_done);
    int s, d0;
    d0 = done_cnt;
    sub_start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    sub_start = 1'b0;
    if (stall_len > 0) begin
      wait_until(s + stall_off);
      force_empty = 1'b1;
      wait_until(s + stall_off + stall_len);
      force_empty = 1'b0;
    end
    if (restart_at > 0) begin
      wait_until(s + restart_at);
      sub_start = 1'b1;
      @(posedge clk); #1;
      sub_start = 1'b0;
    end
    if (clr_at_done) begin
      wait_until(s + DUR);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
    end
    for (int i = 0; i < 3 * DUR && done_cnt == d0; i++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int k, s;
    rst = 1'b1; sub_start = 1'b0; cnt_clr = 1'b0; force_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end

    load(0); run_sub(0, 0, 0, 1'b0);
    load(1); run_sub(0, 0, 0, 1'b0);
    load(2); run_sub(0, 0, 0, 1'b0);
    load(2); run_sub(0, 0, 0, 1'b0);

    // stall at word 5 of row 3: its fetch cycle from the unstalled timeline
    k = 3 * WPR + 5;
    exp_stall = 50;
    load(2); run_sub(1 + k * WT + k / WPR, 50, 0, 1'b0);
    exp_stall = 0;

    load(2); run_sub(0, 0, 100, 1'b0);

    // abort in row 2, then flush the FIFO and expectations
    load(2);
    sub_start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    sub_start = 1'b0;
    wait_until(s + 2 * ROW_T + 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pushed = popped;
    ewr = erd;
    repeat (3) begin
      @(posedge clk); #1;
    end
    load(0); run_sub(0, 0, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      load(2); run_sub(0, 0, 0, 1'b0);
    end
    load(2); run_sub(0, 0, 0, 1'b1);

    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
